// File: rtl/stopwatch_core.sv
// ----------------------------------------------------------------------------
// stopwatch_core
//
// MM:SS stopwatch / countdown timer engine with BCD digit registers.
// An internal prescaler turns CLK_DIV clock cycles into one counted second.
// The engine counts up or down, accepts BCD presets, wraps or saturates at
// full scale (MAX_MIN:59), and can freeze the displayed digits for lap
// readings while the live count keeps running.
//
// Parameters
//   CLK_DIV  clk cycles per counted second (>= 2)
//   MAX_MIN  highest minute value (9..99)
//   WRAP     1 = up-count wraps MAX_MIN:59 -> 00:00, 0 = saturate and flag done
//   DIGIT_W  width of each digit output (>= 4, upper bits are zero)
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   paused       1 = hold prescaler and digits
//   down         0 = count up, 1 = count down
//   load         preset strobe; load_min / load_sec are BCD {tens,units}
//   lap          single-cycle pulse toggling the lap display hold
//   min_l/min_r  displayed minutes tens / units digit
//   sec_l/sec_r  displayed seconds tens / units digit
//   sec_tick     one-cycle pulse after each counted second
//   lap_active   1 = displayed digits are frozen
//   done         timer expired (down) or saturated (up, WRAP=0)
//   load_err     one-cycle pulse when a preset is rejected
// ----------------------------------------------------------------------------
module stopwatch_core #(
   parameter int CLK_DIV = 100000000,
   parameter int MAX_MIN = 59,
   parameter int WRAP    = 1,
   parameter int DIGIT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               paused,
   input  logic               down,
   input  logic               load,
   input  logic [7:0]         load_min,
   input  logic [7:0]         load_sec,
   input  logic               lap,
   output logic [DIGIT_W-1:0] min_l,
   output logic [DIGIT_W-1:0] min_r,
   output logic [DIGIT_W-1:0] sec_l,
   output logic [DIGIT_W-1:0] sec_r,
   output logic               sec_tick,
   output logic               lap_active,
   output logic               done,
   output logic               load_err
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [3:0]    FULL_MT    = 4'(MAX_MIN / 10);
   localparam logic [3:0]    FULL_MU    = 4'(MAX_MIN % 10);

   // Digit index: 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens
   logic [PW-1:0] presc_reg;
   logic [3:0]    live_reg [4];
   logic [3:0]    snap_reg [4];
   logic          down_prev_reg;

   logic          running;
   logic          tick;
   logic          preset_ok;
   logic          load_ok;
   logic          load_bad;
   logic [3:0]    preset_dig [4];
   logic [3:0]    step_dig [4];
   logic          step_done;
   logic          at_full;
   logic          at_zero;
   logic          at_one;

   // ------------------------------------------------------------------------
   // Prescaler gating and preset validation
   // ------------------------------------------------------------------------
   always_comb begin
      running   = !paused && !done;
      tick      = running && (presc_reg == PRESC_LAST);

      preset_ok = (load_sec[3:0] <= 4'd9) && (load_sec[7:4] <= 4'd5) &&
                  (load_min[3:0] <= 4'd9) &&
                  ((int'(load_min[7:4]) * 10 + int'(load_min[3:0])) <= MAX_MIN);
      load_ok   = load && preset_ok;
      load_bad  = load && !preset_ok;

      preset_dig[0] = load_sec[3:0];
      preset_dig[1] = load_sec[7:4];
      preset_dig[2] = load_min[3:0];
      preset_dig[3] = load_min[7:4];
   end

   // ------------------------------------------------------------------------
   // One-second step: BCD increment / decrement with full-scale handling
   // ------------------------------------------------------------------------
   always_comb begin
      step_dig  = live_reg;
      step_done = 1'b0;

      at_full = (live_reg[3] == FULL_MT) && (live_reg[2] == FULL_MU) &&
                (live_reg[1] == 4'd5)    && (live_reg[0] == 4'd9);
      at_zero = (live_reg[3] == 4'd0) && (live_reg[2] == 4'd0) &&
                (live_reg[1] == 4'd0) && (live_reg[0] == 4'd0);
      at_one  = (live_reg[3] == 4'd0) && (live_reg[2] == 4'd0) &&
                (live_reg[1] == 4'd0) && (live_reg[0] == 4'd1);

      if (!down) begin
         if (at_full) begin
            if (WRAP != 0) begin
               for (int i = 0; i < 4; i++) step_dig[i] = 4'd0;
            end else begin
               step_done = 1'b1;     // saturate: digits hold
            end
         end else if (live_reg[0] != 4'd9) begin
            step_dig[0] = live_reg[0] + 4'd1;
         end else begin
            step_dig[0] = 4'd0;
            if (live_reg[1] != 4'd5) begin
               step_dig[1] = live_reg[1] + 4'd1;
            end else begin
               step_dig[1] = 4'd0;
               if (live_reg[2] != 4'd9) begin
                  step_dig[2] = live_reg[2] + 4'd1;
               end else begin
                  step_dig[2] = 4'd0;
                  step_dig[3] = live_reg[3] + 4'd1;
               end
            end
         end
      end else begin
         if (at_zero) begin
            step_done = 1'b1;        // never step below 00:00
         end else begin
            step_done = at_one;      // 00:01 -> 00:00 expires on this edge
            if (live_reg[0] != 4'd0) begin
               step_dig[0] = live_reg[0] - 4'd1;
            end else begin
               step_dig[0] = 4'd9;
               if (live_reg[1] != 4'd0) begin
                  step_dig[1] = live_reg[1] - 4'd1;
               end else begin
                  step_dig[1] = 4'd5;
                  if (live_reg[2] != 4'd0) begin
                     step_dig[2] = live_reg[2] - 4'd1;
                  end else begin
                     step_dig[2] = 4'd9;
                     step_dig[3] = live_reg[3] - 4'd1;
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg     <= '0;
         down_prev_reg <= 1'b0;
         sec_tick      <= 1'b0;
         lap_active    <= 1'b0;
         done          <= 1'b0;
         load_err      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            live_reg[i] <= 4'd0;
            snap_reg[i] <= 4'd0;
         end
      end else begin
         sec_tick      <= 1'b0;
         load_err      <= load_bad;
         down_prev_reg <= down;

         if (load_ok) begin
            // An accepted preset overrides any tick or lap on the same edge
            live_reg   <= preset_dig;
            presc_reg  <= '0;
            done       <= 1'b0;
            lap_active <= 1'b0;
         end else begin
            // A rejected preset leaves counting untouched
            if (running) begin
               presc_reg <= tick ? '0 : presc_reg + PW'(1);
            end

            if (tick) begin
               live_reg <= step_dig;
               sec_tick <= 1'b1;
            end

            // Expiry on this edge wins over a simultaneous direction change
            if (tick && step_done) begin
               done <= 1'b1;
            end else if (down != down_prev_reg) begin
               done <= 1'b0;
            end

            // Snapshot uses the pre-tick digits
            if (lap) begin
               if (!lap_active) begin
                  snap_reg   <= live_reg;
                  lap_active <= 1'b1;
               end else begin
                  lap_active <= 1'b0;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Display mux: frozen snapshot or live count, zero-extended
   // ------------------------------------------------------------------------
   logic [3:0] disp [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_disp
         assign disp[gi] = lap_active ? snap_reg[gi] : live_reg[gi];
      end
   endgenerate

   assign sec_r = DIGIT_W'(disp[0]);
   assign sec_l = DIGIT_W'(disp[1]);
   assign min_r = DIGIT_W'(disp[2]);
   assign min_l = DIGIT_W'(disp[3]);

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

   localparam int CLK_DIV = 4;
   localparam int DW      = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic paused = 1'b0;
   logic down = 1'b0;
   logic load = 1'b0;
   logic lap = 1'b0;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;

   always #5 clk = ~clk;

   logic [DW-1:0] ml0, mr0, sl0, sr0, ml1, mr1, sl1, sr1;
   logic tk0, la0, dn0, le0, tk1, la1, dn1, le1;

   stopwatch_core #(.CLK_DIV(CLK_DIV), .MAX_MIN(59), .WRAP(1), .DIGIT_W(DW)) dut_wrap (
      .clk(clk), .rst(rst), .paused(paused), .down(down), .load(load),
      .load_min(load_min), .load_sec(load_sec), .lap(lap),
      .min_l(ml0), .min_r(mr0), .sec_l(sl0), .sec_r(sr0),
      .sec_tick(tk0), .lap_active(la0), .done(dn0), .load_err(le0));

   stopwatch_core #(.CLK_DIV(CLK_DIV), .MAX_MIN(12), .WRAP(0), .DIGIT_W(DW)) dut_sat (
      .clk(clk), .rst(rst), .paused(paused), .down(down), .load(load),
      .load_min(load_min), .load_sec(load_sec), .lap(lap),
      .min_l(ml1), .min_r(mr1), .sec_l(sl1), .sec_r(sr1),
      .sec_tick(tk1), .lap_active(la1), .done(dn1), .load_err(le1));

   logic [19:0] o_disp [2];
   logic        o_tick [2];
   logic        o_lap  [2];
   logic        o_done [2];
   logic        o_err  [2];

   assign o_disp[0] = {ml0, mr0, sl0, sr0};
   assign o_disp[1] = {ml1, mr1, sl1, sr1};
   assign o_tick[0] = tk0;  assign o_tick[1] = tk1;
   assign o_lap[0]  = la0;  assign o_lap[1]  = la1;
   assign o_done[0] = dn0;  assign o_done[1] = dn1;
   assign o_err[0]  = le0;  assign o_err[1]  = le1;

   // Reference model: time held as a plain count of seconds
   int max_min [2] = '{59, 12};
   int wrap    [2] = '{1, 0};
   int m_secs  [2];
   int m_presc [2];
   int m_snap  [2];
   bit m_done  [2];
   bit m_lap   [2];
   bit m_tick  [2];
   bit m_err   [2];
   bit m_dprev [2];

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [19:0] disp_of(input int s);
      int m;
      int x;
      m = s / 60;
      x = s % 60;
      return {5'(m / 10), 5'(m % 10), 5'(x / 10), 5'(x % 10)};
   endfunction

   function automatic bit preset_valid(input int i, input logic [7:0] lm, input logic [7:0] ls);
      int mt, mu, st, su;
      mt = int'(lm[7:4]); mu = int'(lm[3:0]);
      st = int'(ls[7:4]); su = int'(ls[3:0]);
      return (mu <= 9) && (su <= 9) && (st <= 5) && (mt * 10 + mu <= max_min[i]);
   endfunction

   function automatic int preset_secs(input logic [7:0] lm, input logic [7:0] ls);
      return (int'(lm[7:4]) * 10 + int'(lm[3:0])) * 60 + int'(ls[7:4]) * 10 + int'(ls[3:0]);
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic bit will_tick(input int i);
      return !paused && !m_done[i] && (m_presc[i] == CLK_DIV - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_secs[i] = 0; m_presc[i] = 0; m_snap[i] = 0;
         m_done[i] = 0; m_lap[i] = 0; m_tick[i] = 0; m_err[i] = 0; m_dprev[i] = 0;
      end
   endtask

   // Applied once per rising edge, from the inputs present at that edge
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit tk;
         bit ok;
         bit dset;
         int full;
         tk   = will_tick(i);
         ok   = preset_valid(i, load_min, load_sec);
         full = max_min[i] * 60 + 59;
         m_tick[i] = 0;
         m_err[i]  = load && !ok;
         if (load && ok) begin
            m_secs[i]  = preset_secs(load_min, load_sec);
            m_presc[i] = 0;
            m_done[i]  = 0;
            m_lap[i]   = 0;
         end else begin
            if (!paused && !m_done[i]) m_presc[i] = tk ? 0 : m_presc[i] + 1;
            if (lap) begin
               if (!m_lap[i]) begin
                  m_snap[i] = m_secs[i];
                  m_lap[i]  = 1;
               end else begin
                  m_lap[i] = 0;
               end
            end
            dset = 0;
            if (tk) begin
               m_tick[i] = 1;
               if (!down) begin
                  if (m_secs[i] == full) begin
                     if (wrap[i] != 0) m_secs[i] = 0;
                     else dset = 1;
                  end else begin
                     m_secs[i]++;
                  end
               end else begin
                  if (m_secs[i] == 0) begin
                     dset = 1;
                  end else begin
                     m_secs[i]--;
                     if (m_secs[i] == 0) dset = 1;
                  end
               end
            end
            if (dset) m_done[i] = 1;
            else if (down != m_dprev[i]) m_done[i] = 0;
         end
         m_dprev[i] = down;
      end
   endtask

   task automatic compare_all(input string ph);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_disp%0d", ph, i), 32'(o_disp[i]),
               32'(disp_of(m_lap[i] ? m_snap[i] : m_secs[i])));
         check($sformatf("%s_tick%0d", ph, i), 32'(o_tick[i]), 32'(m_tick[i]));
         check($sformatf("%s_lap%0d", ph, i),  32'(o_lap[i]),  32'(m_lap[i]));
         check($sformatf("%s_done%0d", ph, i), 32'(o_done[i]), 32'(m_done[i]));
         check($sformatf("%s_err%0d", ph, i),  32'(o_err[i]),  32'(m_err[i]));
      end
   endtask

   task automatic cyc(input string ph);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(ph);
   endtask

   task automatic run(input int n, input string ph);
      repeat (n) cyc(ph);
   endtask

   task automatic do_load(input logic [7:0] lm, input logic [7:0] ls, input string ph);
      load = 1'b1; load_min = lm; load_sec = ls;
      $display("%s: load %02h:%02h down=%0d", ph, lm, ls, down);
      cyc(ph);
      load = 1'b0;
   endtask

   task automatic do_lap(input string ph);
      lap = 1'b1;
      $display("%s: lap pulse", ph);
      cyc(ph);
      lap = 1'b0;
   endtask

   task automatic check_all_zero(input string ph);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_disp%0d", ph, i), 32'(o_disp[i]), 32'd0);
         check($sformatf("%s_tick%0d", ph, i), 32'(o_tick[i]), 32'd0);
         check($sformatf("%s_lap%0d", ph, i),  32'(o_lap[i]),  32'd0);
         check($sformatf("%s_done%0d", ph, i), 32'(o_done[i]), 32'd0);
         check($sformatf("%s_err%0d", ph, i),  32'(o_err[i]),  32'd0);
      end
   endtask

   initial begin
      logic [7:0] lm;
      logic [7:0] ls;

      // Reset state
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // 1: up-count from reset, tick every 4 clocks, carries
      run(40, "p1");
      check("p1_0010", 32'(o_disp[0]), 32'(disp_of(10)));
      do_load(8'h00, 8'h58, "p1");
      run(8, "p1");
      check("p1_0100", 32'(o_disp[0]), 32'(disp_of(60)));

      // 2: full scale wrap (MAX 59) and saturate (MAX 12, WRAP=0)
      do_load(8'h59, 8'h58, "p2");
      check("p2_err_sat", 32'(o_err[1]), 32'd1);
      run(8, "p2");
      check("p2_wrap_disp", 32'(o_disp[0]), 32'(disp_of(0)));
      check("p2_wrap_done", 32'(o_done[0]), 32'd0);
      do_load(8'h12, 8'h58, "p2");
      run(12, "p2");
      check("p2_sat_disp", 32'(o_disp[1]), 32'(disp_of(12 * 60 + 59)));
      check("p2_sat_done", 32'(o_done[1]), 32'd1);

      // 3: count down to expiry, hold, clear done by direction change
      down = 1'b1;
      do_load(8'h01, 8'h02, "p3");
      run(62 * CLK_DIV, "p3");
      check("p3_zero_disp", 32'(o_disp[0]), 32'd0);
      check("p3_zero_done", 32'(o_done[0]), 32'd1);
      run(8, "p3");
      check("p3_hold_disp", 32'(o_disp[0]), 32'd0);
      down = 1'b0;
      cyc("p3");
      check("p3_clr_done0", 32'(o_done[0]), 32'd0);
      check("p3_clr_done1", 32'(o_done[1]), 32'd0);

      // 4: pause after two prescaler counts
      do_load(8'h00, 8'h00, "p4");
      run(2, "p4");
      paused = 1'b1;
      run(20, "p4");
      check("p4_paused_disp", 32'(o_disp[0]), 32'd0);
      paused = 1'b0;
      cyc("p4");
      check("p4_no_tick_yet", 32'(o_tick[0]), 32'd0);
      cyc("p4");
      check("p4_tick_2clk", 32'(o_tick[0]), 32'd1);
      check("p4_disp_0001", 32'(o_disp[0]), 32'(disp_of(1)));

      // 5: rejected presets, then a valid preset coincident with a tick
      do_load(8'h00, 8'h60, "p5");
      check("p5_err_sec60", 32'(o_err[0]), 32'd1);
      do_load(8'h61, 8'h00, "p5");
      check("p5_err_min61", 32'(o_err[0]), 32'd1);
      check("p5_kept_disp", 32'(o_disp[0]), 32'(disp_of(1)));
      cyc("p5");
      do_load(8'h12, 8'h34, "p5");
      check("p5_load_notick", 32'(o_tick[0]), 32'd0);
      check("p5_load_disp", 32'(o_disp[0]), 32'(disp_of(12 * 60 + 34)));
      run(CLK_DIV, "p5");
      check("p5_next_tick", 32'(o_tick[0]), 32'd1);
      check("p5_next_disp", 32'(o_disp[0]), 32'(disp_of(12 * 60 + 35)));

      // 6: lap freeze and release, then async reset mid-count
      do_load(8'h00, 8'h00, "p6");
      run(20, "p6");
      do_lap("p6");
      check("p6_lap_on", 32'(o_lap[0]), 32'd1);
      check("p6_lap_0005", 32'(o_disp[0]), 32'(disp_of(5)));
      run(15, "p6");
      check("p6_frozen", 32'(o_disp[0]), 32'(disp_of(5)));
      do_lap("p6");
      check("p6_lap_off", 32'(o_lap[0]), 32'd0);
      check("p6_live_0009", 32'(o_disp[0]), 32'(disp_of(9)));
      run(6, "p6");
      #2 rst = 1'b0;
      #1 check_all_zero("p6_async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         paused = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) down = ~down;
         lap  = ($urandom_range(0, 29) == 0);
         load = ($urandom_range(0, 24) == 0);
         if (load) begin
            case ($urandom_range(0, 4))
               0: begin lm = bcd($urandom_range(0, 59)); ls = bcd($urandom_range(0, 59)); end
               1: begin lm = bcd(59); ls = bcd($urandom_range(56, 59)); end
               2: begin lm = bcd(12); ls = bcd($urandom_range(55, 59)); end
               3: begin lm = bcd(0);  ls = bcd($urandom_range(0, 3)); end
               default: begin lm = 8'($urandom); ls = 8'($urandom); end
            endcase
            load_min = lm;
            load_sec = ls;
            // keep rejected presets off tick edges
            if (!(preset_valid(0, lm, ls) && preset_valid(1, lm, ls)) &&
                (will_tick(0) || will_tick(1)))
               load = 1'b0;
         end
         if (load) $display("rnd %0d: load %02h:%02h down=%0d", k, load_min, load_sec, down);
         if (lap)  $display("rnd %0d: lap pulse", k);
         cyc("rnd");
         load = 1'b0;
         lap  = 1'b0;
      end
      paused = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
